// File: rtl/contador_m_redux_multimodo_if.sv
// Control and status bundle for the score-driven multimode counter.
// The master side drives controls; the slave side is the counter itself.
interface contador_m_redux_multimodo_if #(
    parameter int unsigned N       = 7,
    parameter int unsigned SCORE_N = 4
);
    logic               zera_s;
    logic               carrega;
    logic [N-1:0]       valor;
    logic               conta;
    logic [SCORE_N-1:0] score;
    logic [1:0]         modo;
    logic [N-1:0]       Q;
    logic [N-1:0]       m_ef;
    logic               fim;
    logic               inicio;
    logic               volta;
    logic               parado;

    modport master (
        output zera_s, carrega, valor, conta, score, modo,
        input  Q, m_ef, fim, inicio, volta, parado
    );

    modport slave (
        input  zera_s, carrega, valor, conta, score, modo,
        output Q, m_ef, fim, inicio, volta, parado
    );
endinterface

// File: rtl/contador_m_redux_multimodo.sv
// Game pacing counter: the modulus shrinks with score; supports up, down, ping-pong
// and one-shot modes, synchronous clear/load and a registered event pulse.
module contador_m_redux_multimodo #(
    parameter int unsigned M       = 64,
    parameter int unsigned N       = 7,
    parameter int unsigned SCORE_N = 4,
    parameter int unsigned MIN_M   = 8,
    parameter int unsigned STEP    = 4
) (
    input  logic                       clock,
    input  logic                       zera_as_n,
    contador_m_redux_multimodo_if.slave bus
);

    localparam int unsigned STEP_W = $clog2(STEP) + 1;
    localparam int unsigned WIDE   = N + SCORE_N + STEP_W + 1;

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_PING = 2'b10;
    localparam logic [1:0] MODO_ONE  = 2'b11;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    logic [N-1:0]    q_q,      q_d;
    logic [0:0]      dir_q,    dir_d;
    logic            volta_q,  volta_d;
    logic            parado_q, parado_d;

    logic [WIDE-1:0] red_w;
    logic [N-1:0]    m_ef_c;
    logic [N-1:0]    top_c;
    logic            in_range_c;

    // Effective modulus: subtraction is evaluated as a compare to avoid going negative.
    always_comb begin
        red_w = WIDE'(bus.score) * WIDE'(STEP);
        if ((red_w + WIDE'(MIN_M)) > WIDE'(M)) begin
            m_ef_c = N'(MIN_M);
        end else begin
            m_ef_c = N'(WIDE'(M) - red_w);
        end
    end

    assign top_c      = m_ef_c - N'(1);
    assign in_range_c = (q_q <= top_c);

    // State registers.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            q_q      <= '0;
            dir_q    <= DIR_UP;
            volta_q  <= 1'b0;
            parado_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            dir_q    <= dir_d;
            volta_q  <= volta_d;
            parado_q <= parado_d;
        end
    end

    // Next-state: zera_s > carrega > conta.
    always_comb begin
        q_d      = q_q;
        dir_d    = dir_q;
        volta_d  = 1'b0;
        parado_d = parado_q;

        if (bus.zera_s) begin
            q_d      = '0;
            dir_d    = DIR_UP;
            parado_d = 1'b0;
        end else if (bus.carrega) begin
            q_d      = (bus.valor > top_c) ? top_c : bus.valor;
            dir_d    = DIR_UP;
            parado_d = 1'b0;
        end else if (bus.conta) begin
            if (!in_range_c) begin
                // Score rose past the current count: snap back into range.
                volta_d = 1'b1;
                case (bus.modo)
                    MODO_UP: begin
                        q_d = '0;
                    end
                    MODO_DOWN: begin
                        q_d = top_c;
                    end
                    MODO_PING: begin
                        q_d   = top_c;
                        dir_d = DIR_DOWN;
                    end
                    default: begin
                        q_d      = '0;
                        parado_d = 1'b1;
                    end
                endcase
            end else begin
                case (bus.modo)
                    MODO_UP: begin
                        if (q_q == top_c) begin
                            q_d     = '0;
                            volta_d = 1'b1;
                        end else begin
                            q_d = q_q + N'(1);
                        end
                    end
                    MODO_DOWN: begin
                        if (q_q == '0) begin
                            q_d     = top_c;
                            volta_d = 1'b1;
                        end else begin
                            q_d = q_q - N'(1);
                        end
                    end
                    MODO_PING: begin
                        if (dir_q == DIR_UP) begin
                            if (q_q == top_c) begin
                                q_d     = q_q - N'(1);
                                dir_d   = DIR_DOWN;
                                volta_d = 1'b1;
                            end else begin
                                q_d = q_q + N'(1);
                            end
                        end else begin
                            if (q_q == '0) begin
                                q_d     = N'(1);
                                dir_d   = DIR_UP;
                                volta_d = 1'b1;
                            end else begin
                                q_d = q_q - N'(1);
                            end
                        end
                    end
                    MODO_ONE: begin
                        if (!parado_q) begin
                            if (q_q == top_c) begin
                                parado_d = 1'b1;
                                volta_d  = 1'b1;
                            end else begin
                                q_d = q_q + N'(1);
                            end
                        end
                    end
                    default: begin
                        q_d = q_q;
                    end
                endcase
            end
        end
    end

    assign bus.Q      = q_q;
    assign bus.m_ef   = m_ef_c;
    assign bus.fim    = (q_q == top_c);
    assign bus.inicio = (q_q == '0);
    assign bus.volta  = volta_q;
    assign bus.parado = parado_q;

endmodule

// File: tb/tb_contador_m_redux_multimodo.sv
// Directed bench for the multimode counter: vector table plus multi-cycle sequences.
module tb_contador_m_redux_multimodo;

    localparam int unsigned N       = 7;
    localparam int unsigned SCORE_N = 4;

    logic clock;
    logic zera_as_n;
    int   tests;
    int   fails;

    contador_m_redux_multimodo_if #(.N(N), .SCORE_N(SCORE_N)) bus ();

    contador_m_redux_multimodo #(
        .M(64), .N(N), .SCORE_N(SCORE_N), .MIN_M(8), .STEP(4)
    ) dut (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .bus       (bus)
    );

    typedef struct {
        logic         zera_s;
        logic         carrega;
        logic [6:0]   valor;
        logic         conta;
        logic [3:0]   score;
        logic [1:0]   modo;
        int           q;
        int           volta;
        int           parado;
        int           fim;
        int           inicio;
        int           m_ef;
    } vec_t;

    vec_t vecs[15];
    int exp2[9]  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int exp3[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic zs, input logic ca, input logic [6:0] va,
                         input logic co, input logic [3:0] sc, input logic [1:0] mo);
        bus.zera_s  = zs;
        bus.carrega = ca;
        bus.valor   = va;
        bus.conta   = co;
        bus.score   = sc;
        bus.modo    = mo;
    endtask

    function automatic vec_t mk(logic zs, logic ca, logic [6:0] va, logic co, logic [3:0] sc,
                                logic [1:0] mo, int q, int vo, int pa, int fi, int ini, int me);
        vec_t v;
        v.zera_s = zs; v.carrega = ca; v.valor = va; v.conta = co; v.score = sc; v.modo = mo;
        v.q = q; v.volta = vo; v.parado = pa; v.fim = fi; v.inicio = ini; v.m_ef = me;
        return v;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        //            zs ca valor co sc modo   q vo pa fi in mef
        vecs[0]  = mk(0, 1, 7'd5,   0, 0, 2'b00, 5, 0, 0, 0, 0, 64);
        vecs[1]  = mk(0, 0, 7'd0,   1, 0, 2'b00, 6, 0, 0, 0, 0, 64);
        vecs[2]  = mk(0, 1, 7'd100, 0, 0, 2'b00, 63, 0, 0, 1, 0, 64);
        vecs[3]  = mk(0, 0, 7'd0,   1, 0, 2'b00, 0, 1, 0, 0, 1, 64);
        vecs[4]  = mk(0, 0, 7'd0,   1, 0, 2'b01, 63, 1, 0, 1, 0, 64);
        vecs[5]  = mk(0, 0, 7'd0,   1, 0, 2'b01, 62, 0, 0, 0, 0, 64);
        vecs[6]  = mk(0, 0, 7'd0,   0, 0, 2'b01, 62, 0, 0, 0, 0, 64);
        vecs[7]  = mk(0, 1, 7'd60,  0, 3, 2'b00, 51, 0, 0, 1, 0, 52);
        vecs[8]  = mk(0, 0, 7'd0,   1, 3, 2'b00, 0, 1, 0, 0, 1, 52);
        vecs[9]  = mk(1, 1, 7'd9,   1, 3, 2'b00, 0, 0, 0, 0, 1, 52);
        vecs[10] = mk(0, 1, 7'd7,   0, 15, 2'b00, 7, 0, 0, 1, 0, 8);
        vecs[11] = mk(0, 0, 7'd0,   1, 15, 2'b10, 6, 1, 0, 0, 0, 8);
        vecs[12] = mk(0, 0, 7'd0,   1, 15, 2'b10, 5, 0, 0, 0, 0, 8);
        vecs[13] = mk(0, 1, 7'd0,   0, 15, 2'b10, 0, 0, 0, 0, 1, 8);
        vecs[14] = mk(0, 0, 7'd0,   1, 15, 2'b10, 1, 0, 0, 0, 0, 8);

        // Asynchronous reset state
        zera_as_n = 1'b0;
        drive(0, 0, 7'd0, 0, 4'd0, 2'b00);
        #2;
        chk("reset_q", 32'(bus.Q), 0);
        chk("reset_volta", 32'(bus.volta), 0);
        chk("reset_parado", 32'(bus.parado), 0);
        chk("reset_mef", 32'(bus.m_ef), 64);
        #10;
        zera_as_n = 1'b1;

        // Up-wrap across 70 edges at m_ef=64
        drive(0, 0, 7'd0, 1, 4'd0, 2'b00);
        for (int i = 0; i < 70; i++) begin
            int e;
            tick();
            e = (i + 1) % 64;
            chk("up_q", 32'(bus.Q), 32'(e));
            chk("up_volta", 32'(bus.volta), (i == 63) ? 1 : 0);
            chk("up_fim", 32'(bus.fim), (e == 63) ? 1 : 0);
            chk("up_inicio", 32'(bus.inicio), (e == 0) ? 1 : 0);
        end
        #2;
        zera_as_n = 1'b0;
        #1;
        chk("async_clear_q", 32'(bus.Q), 0);
        bus.conta = 1'b0;
        #2;
        zera_as_n = 1'b1;

        // Table of single-edge vectors
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].zera_s, vecs[i].carrega, vecs[i].valor, vecs[i].conta,
                  vecs[i].score, vecs[i].modo);
            tick();
            chk($sformatf("vec%0d_q", i), 32'(bus.Q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_volta", i), 32'(bus.volta), 32'(vecs[i].volta));
            chk($sformatf("vec%0d_parado", i), 32'(bus.parado), 32'(vecs[i].parado));
            chk($sformatf("vec%0d_fim", i), 32'(bus.fim), 32'(vecs[i].fim));
            chk($sformatf("vec%0d_inicio", i), 32'(bus.inicio), 32'(vecs[i].inicio));
            chk($sformatf("vec%0d_mef", i), 32'(bus.m_ef), 32'(vecs[i].m_ef));
        end

        // Down-wrap at clamped modulus 8
        drive(1, 0, 7'd0, 0, 4'd15, 2'b01);
        tick();
        bus.zera_s = 1'b0;
        bus.conta  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("down_q", 32'(bus.Q), 32'(exp2[i]));
            chk("down_volta", 32'(bus.volta), (i == 0 || i == 8) ? 1 : 0);
        end

        // Ping-pong at modulus 8
        drive(1, 0, 7'd0, 0, 4'd15, 2'b10);
        tick();
        bus.zera_s = 1'b0;
        bus.conta  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("ping_q", 32'(bus.Q), 32'(exp3[i]));
            chk("ping_volta", 32'(bus.volta), (i == 7 || i == 14) ? 1 : 0);
        end

        // One-shot at modulus 16, then reload clears parado
        drive(1, 0, 7'd0, 0, 4'd12, 2'b11);
        tick();
        chk("oneshot_mef", 32'(bus.m_ef), 16);
        bus.zera_s = 1'b0;
        bus.conta  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("oneshot_q", 32'(bus.Q), (i < 15) ? 32'(i + 1) : 15);
            chk("oneshot_volta", 32'(bus.volta), (i == 15) ? 1 : 0);
            chk("oneshot_parado", 32'(bus.parado), (i >= 15) ? 1 : 0);
        end
        drive(0, 1, 7'd5, 1, 4'd12, 2'b11);
        tick();
        chk("oneshot_reload_q", 32'(bus.Q), 5);
        chk("oneshot_reload_parado", 32'(bus.parado), 0);

        // Score jump leaves Q out of range (up mode)
        drive(0, 1, 7'd40, 0, 4'd0, 2'b00);
        tick();
        bus.carrega = 1'b0;
        bus.score   = 4'd15;
        #1;
        chk("oor_mef", 32'(bus.m_ef), 8);
        chk("oor_fim", 32'(bus.fim), 0);
        chk("oor_inicio", 32'(bus.inicio), 0);
        bus.conta = 1'b1;
        tick();
        chk("oor_up_q", 32'(bus.Q), 0);
        chk("oor_up_volta", 32'(bus.volta), 1);

        // Score jump in ping-pong mode lands on top heading down
        drive(0, 1, 7'd40, 0, 4'd0, 2'b10);
        tick();
        bus.carrega = 1'b0;
        bus.score   = 4'd15;
        bus.conta   = 1'b1;
        tick();
        chk("oor_ping_q", 32'(bus.Q), 7);
        chk("oor_ping_volta", 32'(bus.volta), 1);
        tick();
        chk("oor_ping_dir_q", 32'(bus.Q), 6);
        chk("oor_ping_volta2", 32'(bus.volta), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
